ahb_bus_arbiter: RTL

//  Two-master to one-slave AHB-Lite arbiter. m0 is the instruction fetch bus, m1 is the LSU data bus.

---
 rtl/ahb_bus_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: two-master AHB-Lite arbiter sharing one slave, zero added latency when uncontended;
// a losing address phase is parked in a one-entry per-master buffer and reissued later.
module ahb_bus_arbiter #(
  parameter int AW      = 32,
  parameter bit RR_MODE = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    m0_htrans,
  input  logic          m0_hwrite,
  input  logic [2:0]    m0_hsize,
  input  logic [AW-1:0] m0_haddr,
  input  logic [31:0]   m0_hwdata,
  output logic          m0_hready,
  output logic          m0_hresp,
  output logic [31:0]   m0_hrdata,
  input  logic [1:0]    m1_htrans,
  input  logic          m1_hwrite,
  input  logic [2:0]    m1_hsize,
  input  logic [AW-1:0] m1_haddr,
  input  logic [31:0]   m1_hwdata,
  output logic          m1_hready,
  output logic          m1_hresp,
  output logic [31:0]   m1_hrdata,
  output logic [1:0]    s_htrans,
  output logic          s_hwrite,
  output logic [2:0]    s_hsize,
  output logic [AW-1:0] s_haddr,
  output logic [31:0]   s_hwdata,
  input  logic          s_hready,
  input  logic          s_hresp,
  input  logic [31:0]   s_hrdata
);
  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;
  state_t          st [2];
  state_t          st_nx [2];
  logic            hwrite [2];
  logic [2:0]      hsize [2];
  logic [AW-1:0]   haddr [2];
  logic            b_write [2];
  logic [2:0]      b_size [2];
  logic [AW-1:0]   b_addr [2];
  logic [1:0]      req, hready, accept, cand, grant, hresp;
  logic            gid, last_grant, dp_valid, dp_owner;
  logic            c_write, r_write;
  logic [2:0]      c_size, r_size;
  logic [AW-1:0]   c_addr, r_addr;
  logic            unused;
  assign unused = ^{m0_htrans[0], m1_htrans[0]};
  assign req    = {m1_htrans[1], m0_htrans[1]};
  assign hwrite = '{m0_hwrite, m1_hwrite};
  assign hsize  = '{m0_hsize, m1_hsize};
  assign haddr  = '{m0_haddr, m1_haddr};
  for (genvar g = 0; g < 2; g++) begin : gm
    assign hready[g] = st[g] == IDLE ? 1'b1 : st[g] == DATA ? s_hready : 1'b0;
    assign accept[g] = hready[g] & req[g];
    assign cand[g]   = s_hready & ((st[g] == WAIT) | accept[g]);
    assign hresp[g]  = (st[g] == DATA && dp_valid && dp_owner == 1'(g)) ? s_hresp : 1'b0;
  end
  assign gid   = &cand ? (RR_MODE ? ~last_grant : 1'b1) : cand[1];
  assign grant = |cand ? (gid ? 2'b10 : 2'b01) : 2'b00;
  // a waiting master reissues from its buffer, an accepting one straight from its ports
  assign c_write = st[gid] == WAIT ? b_write[gid] : hwrite[gid];
  assign c_size  = st[gid] == WAIT ? b_size[gid] : hsize[gid];
  assign c_addr  = st[gid] == WAIT ? b_addr[gid] : haddr[gid];
  always_comb begin
    for (int i = 0; i < 2; i++)
      st_nx[i] = accept[i] ? (grant[i] ? DATA : WAIT) :
                 (st[i] == WAIT && grant[i]) ? DATA :
                 (st[i] == DATA && s_hready) ? IDLE : st[i];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        st[i]      <= IDLE;
        b_write[i] <= 1'b0;
        b_size[i]  <= '0;
        b_addr[i]  <= '0;
      end
      last_grant <= 1'b1;
      dp_valid   <= 1'b0;
      dp_owner   <= 1'b0;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st[i] <= st_nx[i];
        if (accept[i] && !grant[i]) begin
          b_write[i] <= hwrite[i];
          b_size[i]  <= hsize[i];
          b_addr[i]  <= haddr[i];
        end
      end
      if (s_hready) begin
        dp_valid <= |grant;
        dp_owner <= gid;
      end
      if (|grant) begin
        last_grant <= gid;
        r_write    <= c_write;
        r_size     <= c_size;
        r_addr     <= c_addr;
      end
    end
  end
  assign s_htrans  = |grant ? 2'b10 : 2'b00;
  assign s_hwrite  = |grant ? c_write : r_write;
  assign s_hsize   = |grant ? c_size : r_size;
  assign s_haddr   = |grant ? c_addr : r_addr;
  assign s_hwdata  = dp_owner ? m1_hwdata : m0_hwdata;
  assign m0_hready = hready[0];
  assign m1_hready = hready[1];
  assign m0_hresp  = hresp[0];
  assign m1_hresp  = hresp[1];
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
endmodule
